// File: rtl/pixel_compositor_if.sv
// rtl/pixel_compositor_if.sv - scan, layer, game-control and RGB bundle for pixel_compositor
interface pixel_compositor_if #(
  parameter int NLAYERS = 4
);
  logic               pix_en;
  logic [31:0]        vgaX;
  logic [31:0]        vgaY;
  logic [NLAYERS-1:0] layerGrey;
  logic [NLAYERS-1:0] layerWhite;
  logic [1:0]         gameState;
  logic               frameTick;
  logic               nightToggle;
  logic [2:0]         vgaRed;
  logic [2:0]         vgaGreen;
  logic [1:0]         vgaBlue;

  modport master (
    output pix_en, vgaX, vgaY, layerGrey, layerWhite, gameState, frameTick, nightToggle,
    input  vgaRed, vgaGreen, vgaBlue
  );

  modport slave (
    input  pix_en, vgaX, vgaY, layerGrey, layerWhite, gameState, frameTick, nightToggle,
    output vgaRed, vgaGreen, vgaBlue
  );
endinterface

// File: rtl/pixel_compositor.sv
// rtl/pixel_compositor.sv - prioritised layer merge with day/night fade and death flash
module pixel_compositor #(
  parameter int NLAYERS      = 4,
  parameter int ScreenW      = 640,
  parameter int ScreenH      = 480,
  parameter int FADE_DIV     = 2,
  parameter int FLASH_FRAMES = 8,
  parameter int FLASH_COUNT  = 3
) (
  input  logic clk,
  input  logic rst,
  pixel_compositor_if.slave bus
);
  typedef enum logic [1:0] {DAY, TO_NIGHT, NIGHT, TO_DAY} fade_e;
  typedef enum logic {IDLE, FLASH} flash_e;
  typedef enum logic [1:0] {BLANK, FG, BG} cls_e;

  localparam int HALVES = 2 * FLASH_COUNT;

  fade_e       fade_q;
  logic [2:0]  lvl_q;
  logic [15:0] div_q;
  flash_e      flash_q;
  logic        inv_q;
  logic [15:0] ph_q;
  logic [15:0] half_q;
  logic [1:0]  prev_gs_q;
  cls_e        class_q, class_d;
  logic [7:0]  rgb_q, rgb_d;
  logic        dead;
  logic        hit;
  logic [2:0]  val;

  assign dead = (bus.gameState == 2'b10);

  always_ff @(posedge clk) begin
    if (rst) begin
      fade_q <= DAY;
      lvl_q  <= 3'd0;
      div_q  <= '0;
    end else begin
      case (fade_q)
        DAY: if (bus.nightToggle) begin
          fade_q <= TO_NIGHT;
          div_q  <= '0;
        end
        NIGHT: if (bus.nightToggle) begin
          fade_q <= TO_DAY;
          div_q  <= '0;
        end
        TO_NIGHT: if (bus.frameTick) begin
          if (div_q == 16'(FADE_DIV - 1)) begin
            div_q <= '0;
            if (lvl_q != 3'd7) lvl_q <= lvl_q + 3'd1;
            if (lvl_q >= 3'd6) fade_q <= NIGHT;
          end else begin
            div_q <= div_q + 16'd1;
          end
        end
        TO_DAY: if (bus.frameTick) begin
          if (div_q == 16'(FADE_DIV - 1)) begin
            div_q <= '0;
            if (lvl_q != 3'd0) lvl_q <= lvl_q - 3'd1;
            if (lvl_q <= 3'd1) fade_q <= DAY;
          end else begin
            div_q <= div_q + 16'd1;
          end
        end
      endcase
    end
  end

  // ph_q counts ticks within a half-period, half_q counts completed half-periods
  always_ff @(posedge clk) begin
    if (rst) begin
      flash_q   <= IDLE;
      inv_q     <= 1'b0;
      ph_q      <= '0;
      half_q    <= '0;
      prev_gs_q <= 2'b00;
    end else begin
      prev_gs_q <= bus.gameState;
      case (flash_q)
        IDLE: if (dead && prev_gs_q != 2'b10) begin
          flash_q <= FLASH;
          inv_q   <= 1'b1;
          ph_q    <= '0;
          half_q  <= '0;
        end
        FLASH: if (!dead) begin
          flash_q <= IDLE;
          inv_q   <= 1'b0;
        end else if (bus.frameTick) begin
          if (ph_q == 16'(FLASH_FRAMES - 1)) begin
            ph_q <= '0;
            if (half_q == 16'(HALVES - 1)) begin
              flash_q <= IDLE;
              inv_q   <= 1'b0;
            end else begin
              half_q <= half_q + 16'd1;
              inv_q  <= ~inv_q;
            end
          end else begin
            ph_q <= ph_q + 16'd1;
          end
        end
      endcase
    end
  end

  always_comb begin
    hit     = 1'b0;
    class_d = BG;
    for (int i = 0; i < NLAYERS; i++) begin
      if (!hit && (bus.layerGrey[i] || bus.layerWhite[i])) begin
        hit     = 1'b1;
        class_d = bus.layerGrey[i] ? FG : BG;
      end
    end
    if (bus.vgaX >= 32'(ScreenW) || bus.vgaY >= 32'(ScreenH)) class_d = BLANK;
  end

  // BG is the complement of the fade level; the flash swaps which class gets which
  always_comb begin
    val   = ((class_q == FG) ^ inv_q) ? lvl_q : ~lvl_q;
    rgb_d = (class_q == BLANK) ? 8'd0 : {val, val, val[2:1]};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      class_q <= BLANK;
      rgb_q   <= 8'd0;
    end else if (bus.pix_en) begin
      class_q <= class_d;
      rgb_q   <= rgb_d;
    end
  end

  assign bus.vgaRed   = rgb_q[7:5];
  assign bus.vgaGreen = rgb_q[4:2];
  assign bus.vgaBlue  = rgb_q[1:0];
endmodule

// File: tb/tb_pixel_compositor.sv
// tb/tb_pixel_compositor.sv - randomized and directed checks of pixel_compositor against a frame-count model
module tb_pixel_compositor;
  localparam int FD = 2;
  localparam int FF = 8;
  localparam int FC = 3;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pixel_compositor_if #(.NLAYERS(4)) bus ();

  pixel_compositor dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_chk = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  wire [7:0] rgb = {bus.vgaRed, bus.vgaGreen, bus.vgaBlue};

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Model: fade level from ticks counted since the toggle, flash phase from ticks since death
  int         m_mode;
  int         m_ticks;
  int         m_lvl;
  bit         m_flashing;
  int         m_fticks;
  logic [1:0] m_prev;
  int         m_cls;
  logic [7:0] m_rgb;

  function automatic logic [7:0] colour(input int cls, input int lvl, input bit inv);
    int v;
    logic [2:0] b;
    if (cls == 0) return 8'd0;
    v = ((cls == 1) != inv) ? lvl : 7 - lvl;
    b = 3'(v);
    return {b, b, b[2:1]};
  endfunction

  function automatic int classify();
    if (bus.vgaX >= 640 || bus.vgaY >= 480) return 0;
    for (int i = 0; i < 4; i++) begin
      if (bus.layerGrey[i]) return 1;
      if (bus.layerWhite[i]) return 2;
    end
    return 2;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_mode = 0; m_ticks = 0; m_lvl = 0;
      m_flashing = 0; m_fticks = 0; m_prev = 2'b00;
      m_cls = 0; m_rgb = 8'd0;
    end else begin
      if (bus.pix_en) begin
        m_rgb = colour(m_cls, m_lvl, m_flashing && ((m_fticks / FF) % 2 == 0));
        m_cls = classify();
      end
      case (m_mode)
        0: if (bus.nightToggle) begin m_mode = 1; m_ticks = 0; end
        2: if (bus.nightToggle) begin m_mode = 3; m_ticks = 0; end
        1: if (bus.frameTick) begin
          m_ticks++;
          m_lvl = (m_ticks / FD > 7) ? 7 : m_ticks / FD;
          if (m_lvl == 7) m_mode = 2;
        end
        default: if (bus.frameTick) begin
          m_ticks++;
          m_lvl = (7 - m_ticks / FD < 0) ? 0 : 7 - m_ticks / FD;
          if (m_lvl == 0) m_mode = 0;
        end
      endcase
      if (!m_flashing) begin
        if (bus.gameState == 2'b10 && m_prev != 2'b10) begin m_flashing = 1; m_fticks = 0; end
      end else if (bus.gameState != 2'b10) begin
        m_flashing = 0;
      end else if (bus.frameTick) begin
        m_fticks++;
        if (m_fticks == 2 * FC * FF) m_flashing = 0;
      end
      m_prev = bus.gameState;
    end
  end

  always @(negedge clk) if (chk_en) check("model", rgb, m_rgb);

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    steps(2);
    rst = 1'b0;
  endtask

  task automatic tick();
    bus.frameTick = 1'b1;
    step();
    bus.frameTick = 1'b0;
    step();
  endtask

  task automatic toggle();
    bus.nightToggle = 1'b1;
    step();
    bus.nightToggle = 1'b0;
  endtask

  task automatic pixel(input logic [3:0] g, input logic [3:0] w);
    bus.vgaX = 32'd100;
    bus.vgaY = 32'd50;
    bus.layerGrey = g;
    bus.layerWhite = w;
  endtask

  initial begin
    logic [2:0] l3;
    rst = 1'b1;
    bus.pix_en = 1'b0; bus.vgaX = '0; bus.vgaY = '0;
    bus.layerGrey = '0; bus.layerWhite = '0; bus.gameState = 2'b00;
    bus.frameTick = 1'b0; bus.nightToggle = 1'b0;
    do_reset();
    check("reset_rgb", rgb, 8'h00);
    chk_en = 1'b1;

    bus.vgaX = 32'd700; bus.vgaY = 32'd10;
    bus.layerGrey = 4'hF; bus.layerWhite = 4'hF; bus.pix_en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      check("blank_x", rgb, 8'h00);
    end

    repeat (6000) begin
      bus.pix_en = ($urandom_range(0, 3) != 0);
      bus.vgaX = 32'($urandom_range(0, 700));
      bus.vgaY = 32'($urandom_range(0, 520));
      bus.layerGrey = 4'($urandom);
      bus.layerWhite = 4'($urandom);
      bus.frameTick = ($urandom_range(0, 3) == 0);
      bus.nightToggle = ($urandom_range(0, 40) == 0);
      if ($urandom_range(0, 150) == 0) bus.gameState = 2'($urandom);
      if ($urandom_range(0, 2500) == 0) rst = 1'b1; else rst = 1'b0;
      step();
    end
    rst = 1'b0; bus.frameTick = 1'b0; bus.nightToggle = 1'b0; bus.pix_en = 1'b1;
    bus.gameState = 2'b01;

    do_reset();
    pixel(4'b0010, 4'b0001);
    steps(2);
    check("prio_white", rgb, 8'hFF);
    pixel(4'b0001, 4'b0001);
    steps(2);
    check("prio_grey", rgb, 8'h00);

    toggle();
    for (int k = 1; k <= 14; k++) begin
      tick();
      if (k == 5) toggle();
      if (k % 2 == 0) begin
        steps(2);
        l3 = 3'(k / 2);
        check("fade_lvl", rgb, {l3, l3, l3[2:1]});
      end
    end
    steps(2);
    check("night_fg", rgb, 8'hFF);
    pixel(4'b0000, 4'b0000);
    steps(2);
    check("night_bg", rgb, 8'h00);

    do_reset();
    pixel(4'b0000, 4'b0100);
    steps(3);
    check("day_bg", rgb, 8'hFF);
    bus.gameState = 2'b10;
    for (int t = 0; t <= 2 * FC * FF; t++) begin
      steps(3);
      check("flash", rgb, (t < 2 * FC * FF && (t / FF) % 2 == 0) ? 8'h00 : 8'hFF);
      if (t < 2 * FC * FF) tick();
    end
    repeat (10) tick();
    steps(2);
    check("no_retrigger", rgb, 8'hFF);

    bus.gameState = 2'b01;
    step();
    bus.gameState = 2'b10;
    steps(3);
    check("flash_start", rgb, 8'h00);
    repeat (3) tick();
    bus.gameState = 2'b00;
    steps(3);
    check("flash_abort", rgb, 8'hFF);
    bus.gameState = 2'b10;
    steps(3);
    check("flash_restart", rgb, 8'h00);
    bus.gameState = 2'b01;

    do_reset();
    pixel(4'b1000, 4'b0000);
    toggle();
    repeat (8) tick();
    steps(2);
    check("mid_fade_lvl4", rgb, 8'h92);
    rst = 1'b1;
    step();
    rst = 1'b0;
    pixel(4'b0000, 4'b0010);
    steps(2);
    check("reset_mid_fade", rgb, 8'hFF);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
